ripple_count_capture: RTL and testbench
=======================================

// Module: ripple_count_capture
// PURPOSE
//  Consumes the 4-bit down-counting output of the event ripple counter, which is clocked by an
//  asynchronous event clock and glitches through intermediate codes while bits ripple.
//  Synchronises and de-glitches that output into the clk domain.
//  Extends it into a WIDTH-bit up-count of events, with threshold pulse and snapshot readout.
//  Sits between the ripple counter and the register/readout logic.
// PARAMETERS
//  WIDTH      16   width of accumulated event total
//  SYNC_STG   2    synchroniser flops per bit (>=2)
// PORTS
//  clk         in   1      system clock
//  rstn        in   1      reset, asynchronous, active-low
//  rc_in       in   4      ripple counter output; async to clk; counts down 15..0, then wraps to 15
//  clr         in   1      sync clear of total (ripple counter itself untouched)
//  thresh      in   WIDTH  threshold for thr_hit; quasi-static
//  snap_req    in   1      1-cycle request to capture total
//  snap_ready  in   1      consumer accepts snapshot
//  snap_valid  out  1      snapshot held on snap_data
//  snap_data   out  WIDTH  captured total
//  total       out  WIDTH  live event total
//  thr_hit     out  1      1-cycle pulse when total reaches thresh
//  ovf         out  1      sticky: total wrapped past 2^WIDTH-1
// BEHAVIOUR
//  Reset values (async, rstn=0): total=0, snap_valid=0, snap_data=0, thr_hit=0, ovf=0.
//  Reset state: sync flops=4'hF; FSM in ST_INIT.
//  Sync: rc_in passes through SYNC_STG flops -> s_q.
//  Prev register p_q holds s_q from the previous cycle.
//  Stable sample: s_q==p_q. Unequal cycles are transient and ignored.
//  FSM ST_INIT: on first stable sample, base<=s_q and go to ST_RUN; total stays 0.
//  FSM ST_RUN: on a stable sample with s_q!=base:
//    delta = (base - s_q) mod 16, 4-bit wrap arithmetic
//    base <= s_q
//    total <= total + delta, mod 2^WIDTH
//  Down-wrap 0->15 is handled by the mod-16 delta.
//  Rate limit: <=15 events per stable window, i.e. per (SYNC_STG+2) clk. Faster is out of spec; no detection.
//  Latency: rc_in settled -> total updated in SYNC_STG+2 clk (4 at default).
//  ovf: set when the addition carries out of WIDTH bits. Cleared only by clr or reset.
//  thr_hit: pulses 1 cycle when total goes from <thresh to >=thresh.
//    Re-arms after total drops below thresh again (clr or wrap).
//    thresh==0: never pulses.
//  clr: total<=0, ovf<=0, base<=current stable s_q (or remain ST_INIT).
//    Same-cycle delta is discarded; clr wins.
//  Snapshot: snap_req while snap_valid=0 -> next cycle snap_valid=1, snap_data=total.
//    Uses the value before any same-cycle update or clr.
//    Holds while snap_valid=1 and snap_ready=0.
//    Drops on the cycle after snap_valid&snap_ready.
//    snap_req while snap_valid=1 is ignored.
//    snap_data stays stable while valid, regardless of total or clr.
//  Mid-operation reset: everything returns to reset values; FSM returns to ST_INIT.
//    Events during reset are lost; a new baseline is taken on exit.
// STRUCTURE
//  Shared package rcc_pkg:
//    FSM state enum {ST_INIT, ST_RUN}
//    localparam RC_W=4, RC_MOD=16
//    default WIDTH
//  Sub-module rcc_bus_sync (N-bit, SYNC_STG-deep flop chain, async reset to all-ones).
//  Instantiate once for rc_in; all other logic stays in this module.
// TESTING
//  1 Reset, rc_in=F, 5 clean decrements F->A spaced 8 clk -> total=5, 4 clk after last change; thr_hit=0.
//  2 20 events, incl. 3->0->F->C wrap -> total=20, ovf=0.
//    Then burst of 3 events inside one window -> total=23.
//  3 Glitch: rc_in 8 -> 0 for 1 clk -> 7 -> total +1 only; no transient 8-count jump.
//  4 thresh=10, count to 12 -> single thr_hit pulse at total 9->10.
//    clr -> total=0, no pulse; recount to 10 -> second pulse.
//  5 total=7: snap_req with snap_ready=0 for 5 clk while events continue
//    -> snap_data=7 held, snap_valid=1.
//    2nd snap_req ignored; ready=1 -> valid drops next clk.
//  6 WIDTH=4 build: 17 events -> total=1, ovf=1.
//    Reset asserted mid-count -> all outputs 0, next event after release not counted until baseline taken.

Source files
------------

// File: rtl/rcc_pkg.sv
// Shared types and constants for the ripple-counter capture block.
package rcc_pkg;
  localparam int unsigned RC_W         = 4;
  localparam int unsigned RC_MOD       = 16;
  localparam int unsigned DEF_WIDTH    = 16;
  localparam int unsigned DEF_SYNC_STG = 2;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  // Events between two down-counter codes, wrapping 0 -> 15.
  function automatic logic [RC_W-1:0] rc_delta(input logic [RC_W-1:0] base,
                                               input logic [RC_W-1:0] cur);
    return RC_W'((RC_MOD + 32'(base) - 32'(cur)) % RC_MOD);
  endfunction
endpackage

// File: rtl/rcc_bus_sync.sv
// N-bit multi-flop synchroniser; resets to all-ones to match the counter's start code.
module rcc_bus_sync #(
  parameter int unsigned N   = 4,
  parameter int unsigned STG = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] d,
  output logic [N-1:0] sync_q
);
  logic [STG-1:0][N-1:0] stg_q;
  logic [STG-1:0][N-1:0] stg_d;

  always_comb begin
    stg_d    = stg_q;
    stg_d[0] = d;
    for (int i = 1; i < int'(STG); i++) begin
      stg_d[i] = stg_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stg_q <= '1;
    end else begin
      stg_q <= stg_d;
    end
  end

  assign sync_q = stg_q[STG-1];
endmodule

// File: rtl/ripple_count_capture.sv
// Turns the async 4-bit down-counting ripple code into a clk-domain WIDTH-bit event total
// with threshold pulse, sticky overflow and a ready/valid snapshot register.
module ripple_count_capture
  import rcc_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned SYNC_STG = DEF_SYNC_STG
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [RC_W-1:0]  rc_in,
  input  logic             clr,
  input  logic [WIDTH-1:0] thresh,
  input  logic             snap_req,
  input  logic             snap_ready,
  output logic             snap_valid,
  output logic [WIDTH-1:0] snap_data,
  output logic [WIDTH-1:0] total,
  output logic             thr_hit,
  output logic             ovf
);
  localparam int unsigned FILL_W = $clog2(SYNC_STG + 1);
  localparam int unsigned SUM_W  = WIDTH + 1;

  logic [RC_W-1:0]   s_q;
  logic [RC_W-1:0]   p_q, p_d;
  logic [RC_W-1:0]   base_q, base_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  state_t            state_q, state_d;
  logic [WIDTH-1:0]  total_q, total_d;
  logic [WIDTH-1:0]  snap_data_q, snap_data_d;
  logic              snap_valid_q, snap_valid_d;
  logic              thr_hit_q, thr_hit_d;
  logic              ovf_q, ovf_d;

  logic              stable_c;
  logic              flushed_c;
  logic [RC_W-1:0]   delta_c;
  logic [SUM_W-1:0]  sum_c;

  rcc_bus_sync #(.N(RC_W), .STG(SYNC_STG)) u_sync (
    .clk    (clk),
    .rstn   (rstn),
    .d      (rc_in),
    .sync_q (s_q)
  );

  // The reset all-ones code must drain out of the chain before a baseline is trusted.
  assign flushed_c = (fill_q == FILL_W'(SYNC_STG));
  assign stable_c  = (s_q == p_q);
  assign delta_c   = rc_delta(base_q, s_q);
  assign sum_c     = SUM_W'(total_q) + SUM_W'(delta_c);

  always_comb begin
    state_d      = state_q;
    p_d          = s_q;
    base_d       = base_q;
    fill_d       = fill_q;
    total_d      = total_q;
    ovf_d        = ovf_q;
    snap_valid_d = snap_valid_q;
    snap_data_d  = snap_data_q;

    if (!flushed_c) begin
      fill_d = fill_q + FILL_W'(1);
    end

    case (state_q)
      ST_INIT: begin
        if (flushed_c && stable_c && !clr) begin
          base_d  = s_q;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stable_c && (s_q != base_q)) begin
          base_d  = s_q;
          total_d = sum_c[WIDTH-1:0];
          if (sum_c[WIDTH]) begin
            ovf_d = 1'b1;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase

    // Clear discards any same-cycle delta and re-bases on the current stable code.
    if (clr) begin
      total_d = '0;
      ovf_d   = 1'b0;
      base_d  = base_q;
      if ((state_q == ST_RUN) && stable_c) begin
        base_d = s_q;
      end
    end

    thr_hit_d = (thresh != '0) && (total_q < thresh) && (total_d >= thresh);

    if (!snap_valid_q && snap_req) begin
      snap_valid_d = 1'b1;
      snap_data_d  = total_q;
    end else if (snap_valid_q && snap_ready) begin
      snap_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_INIT;
      p_q          <= '1;
      base_q       <= '1;
      fill_q       <= '0;
      total_q      <= '0;
      ovf_q        <= 1'b0;
      thr_hit_q    <= 1'b0;
      snap_valid_q <= 1'b0;
      snap_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      p_q          <= p_d;
      base_q       <= base_d;
      fill_q       <= fill_d;
      total_q      <= total_d;
      ovf_q        <= ovf_d;
      thr_hit_q    <= thr_hit_d;
      snap_valid_q <= snap_valid_d;
      snap_data_q  <= snap_data_d;
    end
  end

  assign total      = total_q;
  assign ovf        = ovf_q;
  assign thr_hit    = thr_hit_q;
  assign snap_valid = snap_valid_q;
  assign snap_data  = snap_data_q;
endmodule

// File: tb/tb_ripple_count_capture.sv
// Bench for ripple_count_capture: 16-bit and 4-bit instances share stimulus and are
// checked against an event-count model of the ripple counter.
module tb_ripple_count_capture;
  logic        clk = 1'b0;
  logic        rstn, clr, snap_req, snap_ready;
  logic [3:0]  rc_in;
  logic [15:0] thresh16;
  logic [3:0]  thresh4;

  logic        sv16, thr16, ovf16;
  logic [15:0] sd16, tot16;
  logic        sv4, thr4, ovf4;
  logic [3:0]  sd4, tot4;

  always #5 clk = ~clk;

  ripple_count_capture #(.WIDTH(16), .SYNC_STG(2)) u_dut16 (
    .clk(clk), .rstn(rstn), .rc_in(rc_in), .clr(clr), .thresh(thresh16),
    .snap_req(snap_req), .snap_ready(snap_ready), .snap_valid(sv16),
    .snap_data(sd16), .total(tot16), .thr_hit(thr16), .ovf(ovf16));

  ripple_count_capture #(.WIDTH(4), .SYNC_STG(2)) u_dut4 (
    .clk(clk), .rstn(rstn), .rc_in(rc_in), .clr(clr), .thresh(thresh4),
    .snap_req(snap_req), .snap_ready(snap_ready), .snap_valid(sv4),
    .snap_data(sd4), .total(tot4), .thr_hit(thr4), .ovf(ovf4));

  int checks = 0;
  int errors = 0;

  // Model: events seen since the last baseline/clear, plus expected/observed pulse counts.
  longint      ev = 0;
  logic [3:0]  prev_rc = 4'hF;
  int          exp_p16 = 0, exp_p4 = 0, obs_p16 = 0, obs_p4 = 0;
  logic [15:0] last_hit_total = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit crossed(input longint a, input longint b, input int w, input longint th);
    longint m = longint'(1) << w;
    return (th != 0) && ((a % m) < th) && ((b % m) >= th);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Codes held >=2 cycles are real counter states; 1-cycle codes are ripple glitches.
  task automatic step(input logic [3:0] v, input int hold);
    rc_in = v;
    if (hold >= 2) begin
      if (rstn) begin
        longint nev = ev + longint'((int'(prev_rc) - int'(v) + 16) % 16);
        if (crossed(ev, nev, 16, longint'(thresh16))) exp_p16++;
        if (crossed(ev, nev, 4, longint'(thresh4))) exp_p4++;
        ev = nev;
      end
      prev_rc = v;
    end
    tick(hold);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    ev  = 0;
    tick(1);
    clr = 1'b0;
  endtask

  // Compare process: totals once inputs settled, handshake and snapshot data every cycle.
  logic [5:0]  prev_in;
  int          quiet = 0;
  logic        esv16 = 1'b0, esv4 = 1'b0;
  logic [15:0] esd16 = '0;
  logic [3:0]  esd4 = '0;

  always @(negedge clk) begin : cmp
    logic [5:0] cur;
    cur = {rstn, clr, rc_in};
    if (cur !== prev_in) quiet = 0;
    else if (quiet < 1000) quiet++;
    prev_in = cur;
    if (thr16 === 1'b1) begin
      obs_p16++;
      last_hit_total = tot16;
    end
    if (thr4 === 1'b1) obs_p4++;
    if (!rstn) begin
      chk("reset_outputs", {sv16, sd16, tot16, thr16, ovf16, sv4, sd4, tot4, thr4, ovf4}, 64'd0);
      esv16 = 1'b0; esd16 = '0;
      esv4  = 1'b0; esd4  = '0;
    end else begin
      if (quiet >= 4) begin
        chk("total16", tot16, 64'(ev % 65536));
        chk("ovf16", ovf16, 64'(ev >= 65536));
        chk("total4", tot4, 64'(ev % 16));
        chk("ovf4", ovf4, 64'(ev >= 16));
      end
      chk("snap_valid16", sv16, esv16);
      chk("snap_valid4", sv4, esv4);
      if (esv16) chk("snap_data16", sd16, esd16);
      if (esv4) chk("snap_data4", sd4, esd4);
      if (!esv16 && snap_req) begin
        esv16 = 1'b1; esd16 = 16'(ev % 65536);
      end else if (esv16 && snap_ready) begin
        esv16 = 1'b0;
      end
      if (!esv4 && snap_req) begin
        esv4 = 1'b1; esd4 = 4'(ev % 16);
      end else if (esv4 && snap_ready) begin
        esv4 = 1'b0;
      end
    end
  end

  initial begin
    int base_p;
    int mx;
    logic [3:0] v;
    rstn = 1'b0; clr = 1'b0; snap_req = 1'b0; snap_ready = 1'b0;
    rc_in = 4'hF; thresh16 = '0; thresh4 = '0;
    tick(3);
    rstn = 1'b1;
    tick(8);
    chk("t1_total_after_reset", tot16, 64'd0);

    // Clean decrements F->A with exact 4-cycle latency on the last one.
    step(4'hE, 8); step(4'hD, 8); step(4'hC, 8); step(4'hB, 8);
    step(4'hA, 3);
    chk("t1_latency_3clk", tot16, 64'd4);
    tick(1);
    chk("t1_latency_4clk", tot16, 64'd5);
    tick(4);
    chk("t1_no_thr_hit", obs_p16, 64'd0);

    // 20 events including the 0->F wrap, then a 3-event burst in one window.
    do_clr(); tick(6);
    step(4'h7, 8); step(4'h3, 8); step(4'h0, 8); step(4'hF, 8); step(4'hC, 8); step(4'h6, 8);
    chk("t2_total20", tot16, 64'd20);
    chk("t2_ovf16", ovf16, 64'd0);
    step(4'h5, 1); step(4'h4, 1); step(4'h3, 8);
    chk("t2_burst23", tot16, 64'd23);

    // One-cycle glitch 8->0->7 counts a single event.
    step(4'h8, 8);
    mx = 0;
    step(4'h0, 1); step(4'h7, 2);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (int'(tot16) > mx) mx = int'(tot16);
    end
    chk("t3_glitch_total", tot16, 64'd35);
    chk("t3_glitch_max", mx, 64'd35);

    // Threshold pulse, clear, and re-arm.
    thresh16 = 16'd10;
    do_clr(); tick(6);
    base_p = obs_p16;
    v = 4'h7;
    for (int i = 0; i < 12; i++) begin
      v = v - 4'd1;
      step(v, 3);
    end
    tick(6);
    chk("t4_total12", tot16, 64'd12);
    chk("t4_one_pulse", obs_p16 - base_p, 64'd1);
    chk("t4_pulse_at_10", last_hit_total, 64'd10);
    do_clr(); tick(6);
    chk("t4_clr_total", tot16, 64'd0);
    chk("t4_clr_no_pulse", obs_p16 - base_p, 64'd1);
    for (int i = 0; i < 10; i++) begin
      v = v - 4'd1;
      step(v, 3);
    end
    tick(6);
    chk("t4_second_pulse", obs_p16 - base_p, 64'd2);
    chk("pulses16_t4", obs_p16, exp_p16);

    // Snapshot held under back-pressure while counting continues.
    thresh16 = '0;
    do_clr(); tick(6);
    for (int i = 0; i < 7; i++) begin
      v = v - 4'd1;
      step(v, 3);
    end
    tick(6);
    snap_req = 1'b1; tick(1); snap_req = 1'b0;
    v = v - 4'd1; step(v, 2);
    v = v - 4'd1; step(v, 3);
    chk("t5_valid_held", sv16, 64'd1);
    chk("t5_data7", sd16, 64'd7);
    snap_req = 1'b1; tick(1); snap_req = 1'b0;
    tick(6);
    chk("t5_data_after_2nd_req", sd16, 64'd7);
    snap_ready = 1'b1; tick(1); snap_ready = 1'b0;
    chk("t5_valid_dropped", sv16, 64'd0);

    // 4-bit wrap with sticky overflow, then reset mid-count.
    do_clr(); tick(6);
    step(prev_rc - 4'd8, 4); step(prev_rc - 4'd8, 4); step(prev_rc - 4'd1, 8);
    chk("t6_total4", tot4, 64'd1);
    chk("t6_ovf4", ovf4, 64'd1);
    chk("t6_total16", tot16, 64'd17);
    rc_in = prev_rc - 4'd1;
    prev_rc = rc_in;
    tick(1);
    rstn = 1'b0;
    ev = 0;
    tick(1);
    chk("t6_reset_total16", tot16, 64'd0);
    step(prev_rc - 4'd2, 3);
    rstn = 1'b1;
    tick(8);
    chk("t6_after_release", tot16, 64'd0);
    step(prev_rc - 4'd1, 8);
    chk("t6_first_event", tot16, 64'd1);

    // Randomised traffic.
    thresh16 = 16'($urandom_range(1, 120));
    thresh4  = 4'($urandom_range(1, 15));
    for (int it = 0; it < 400; it++) begin
      int r = int'($urandom_range(0, 19));
      if (r < 12) begin
        if ($urandom_range(0, 3) == 0) step(4'($urandom_range(0, 15)), 1);
        step(prev_rc - 4'($urandom_range(1, 15)), int'($urandom_range(2, 6)));
      end else if (r < 14) begin
        tick(int'($urandom_range(4, 8)));
      end else if (r == 14) begin
        tick(5); snap_req = 1'b1; tick(1); snap_req = 1'b0;
      end else if (r == 15) begin
        snap_ready = 1'($urandom_range(0, 1));
        tick(1);
      end else if (r == 16) begin
        tick(5); do_clr();
      end else if (r == 17) begin
        tick(5);
        thresh16 = 16'($urandom_range(0, 400));
        thresh4  = 4'($urandom_range(0, 15));
      end else begin
        tick(1);
      end
    end
    tick(10);
    chk("pulses16_final", obs_p16, exp_p16);
    chk("pulses4_final", obs_p4, exp_p4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
